// File: rtl/mmio_data_fifo_if.sv
// rtl/mmio_data_fifo_if.sv - push/pop/status bundle between the MMIO decoder, the FIFO and the read mux
interface mmio_data_fifo_if #(
  parameter int BITS  = 64,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            wr_en;
  logic [BITS-1:0] wr_data;
  logic            rd_en;
  logic            clr_err;
  logic [BITS-1:0] rd_data;
  logic            rd_valid;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/mmio_data_fifo.sv
// rtl/mmio_data_fifo.sv - circular-buffer FIFO between MMIO writes and registered MMIO read data
module mmio_data_fifo #(
  parameter int BITS  = 64,
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  mmio_data_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BITS-1:0] mem_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BITS-1:0] rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic full, empty, push_ok, pop_ok;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    pop_ok  = bus.rd_en && !empty;
    // A pop in the same cycle frees the slot the push is about to use.
    push_ok = bus.wr_en && (!full || pop_ok);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = pop_ok;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    // Clear first so an error event in the same cycle keeps the bit set.
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_en && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (bus.rd_en && !pop_ok) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left out of reset so it maps onto plain registers or MLAB.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_mmio_data_fifo.sv
// tb/tb_mmio_data_fifo.sv - directed scoreboard bench for mmio_data_fifo
module tb_mmio_data_fifo;
  localparam int BITS  = 64;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  mmio_data_fifo_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  mmio_data_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [BITS-1:0] mq[$];
  logic [BITS-1:0] exp_q[$];
  logic [BITS-1:0] m_rd;
  bit              m_valid;
  bit              m_ov;
  bit              m_un;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_valid"},  64'(bus.rd_valid),  64'(m_valid));
    check({tag, ".rd_data"},   bus.rd_data,        m_rd);
    check({tag, ".count"},     64'(bus.count),     64'(mq.size()));
    check({tag, ".full"},      64'(bus.full),      64'(mq.size() == DEPTH));
    check({tag, ".empty"},     64'(bus.empty),     64'(mq.size() == 0));
    check({tag, ".overflow"},  64'(bus.overflow),  64'(m_ov));
    check({tag, ".underflow"}, 64'(bus.underflow), 64'(m_un));
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_rd    = '0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
  endtask

  task automatic step(input string tag, input bit push, input logic [BITS-1:0] d,
                      input bit pop, input bit clr);
    bit pop_ok;
    bit push_ok;
    bus.wr_en   = push;
    bus.wr_data = d;
    bus.rd_en   = pop;
    bus.clr_err = clr;
    pop_ok  = pop && (mq.size() != 0);
    push_ok = push && ((mq.size() < DEPTH) || pop_ok);
    if (clr) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    if (push && !push_ok) m_ov = 1'b1;
    if (pop && !pop_ok)   m_un = 1'b1;
    if (pop_ok)  exp_q.push_back(mq.pop_front());
    if (push_ok) mq.push_back(d);
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    m_valid = pop_ok;
    if (pop_ok) m_rd = exp_q.pop_front();
    check_all(tag);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    rst_n       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset_idle");
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    // ordering
    step("ord_push0", 1'b1, 64'h11, 1'b0, 1'b0);
    step("ord_push1", 1'b1, 64'h22, 1'b0, 1'b0);
    step("ord_push2", 1'b1, 64'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("ord_pop", 1'b0, '0, 1'b1, 1'b0);
    step("ord_gap", 1'b0, '0, 1'b0, 1'b0);

    // fill and overflow
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 64'hA0 + 64'(i), 1'b0, 1'b0);
    step("ovf_push", 1'b1, 64'hFF, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);

    // underflow, set-wins and clear
    step("unf_pop", 1'b0, '0, 1'b1, 1'b0);
    step("unf_setwins", 1'b0, '0, 1'b1, 1'b1);
    step("clr_err", 1'b0, '0, 1'b0, 1'b1);

    // simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) step("fill_b", 1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0);
    step("full_pushpop", 1'b1, 64'hB8, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain_b", 1'b0, '0, 1'b1, 1'b0);

    // simultaneous push and pop while empty
    step("empty_pushpop", 1'b1, 64'h5, 1'b1, 1'b0);
    step("pop_5", 1'b0, '0, 1'b1, 1'b1);

    // 20 paired push/pop so both pointers wrap twice
    step("wrap_prime", 1'b1, 64'(32'hC000), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [BITS-1:0] w;
      w = {$urandom(), $urandom()};
      step("wrap_pair", 1'b1, w, 1'b1, 1'b0);
    end
    step("wrap_last", 1'b0, '0, 1'b1, 1'b0);

    // mid-operation reset with count=5 and rd_valid in flight
    for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, 64'hD0 + 64'(i), 1'b0, 1'b0);
    step("pre_rst_pop", 1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst_push", 1'b1, 64'hE1, 1'b0, 1'b0);
    step("post_rst_pop", 1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
